// File: rtl/traceback_row_packer_pkg.sv
// traceback_row_packer_pkg: row geometry, direction codes and the address convention
// shared by the traceback memory reader and writer.
package traceback_row_packer_pkg;
   localparam int N             = 8;
   localparam int LOG_N         = 3;
   localparam int DW            = 2;
   localparam int PW            = 8;
   localparam int ROW_WORDS_LOG = 4;
   localparam int AW            = PW + ROW_WORDS_LOG;
   localparam int TW            = 2*PW - LOG_N;

   typedef enum logic [DW-1:0] {
      DIR_DIAG = 2'd0,
      DIR_UP   = 2'd1,
      DIR_LEFT = 2'd2,
      DIR_STOP = 2'd3
   } dir_e;

   typedef enum logic [1:0] {EMPTY, ACCUM, PEND, PEND_ACCUM} state_e;

   // Tag is {x, y[PW-1:LOG_N]}; address is {x[PW-ROW_WORDS_LOG-1:0], y[PW-1:LOG_N]}.
   function automatic logic [AW-1:0] row_addr(input logic [TW-1:0] tag);
      return AW'({tag[PW-LOG_N +: PW-ROW_WORDS_LOG], tag[PW-LOG_N-1:0]});
   endfunction
endpackage

// File: rtl/traceback_row_slot.sv
// traceback_row_slot: one data+mask+tag row register with a whole-word load port and a
// write-entry-j port; wdata_o/wmask_o show the row as it would be after the entry write.
module traceback_row_slot
   import traceback_row_packer_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_i,
   input  logic            wr_i,
   input  logic            fresh_i,
   input  logic [LOG_N-1:0] j_i,
   input  logic [DW-1:0]   dir_i,
   input  logic [N*DW-1:0] data_i,
   input  logic [N-1:0]    mask_i,
   input  logic [TW-1:0]   tag_i,
   output logic [N*DW-1:0] data_o,
   output logic [N-1:0]    mask_o,
   output logic [TW-1:0]   tag_o,
   output logic [N*DW-1:0] wdata_o,
   output logic [N-1:0]    wmask_o
);
   logic [N*DW-1:0] data_q, data_d;
   logic [N-1:0]    mask_q, mask_d;
   logic [TW-1:0]   tag_q, tag_d;
   logic [LOG_N-1:0] k;

   // Entry 0 sits at the MSB end, so its slot index is N-1-j, i.e. ~j for power-of-two N.
   always_comb begin
      k                   = ~j_i;
      wdata_o             = fresh_i ? '0 : data_q;
      wdata_o[k*DW +: DW] = dir_i;
      wmask_o             = fresh_i ? '0 : mask_q;
      wmask_o[k]          = 1'b1;
      data_d              = ld_i ? data_i : wr_i ? wdata_o : data_q;
      mask_d              = ld_i ? mask_i : wr_i ? wmask_o : mask_q;
      tag_d               = (ld_i || wr_i) ? tag_i : tag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         mask_q <= '0;
         tag_q  <= '0;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
         tag_q  <= tag_d;
      end
   end

   assign data_o = data_q;
   assign mask_o = mask_q;
   assign tag_o  = tag_q;
endmodule

// File: rtl/traceback_row_packer.sv
// traceback_row_packer: packs tagged per-cell direction codes into masked row writes.
// TRACEBACK_WRITE_MASK_EN drives the accumulated mask out; otherwise the mask is all-ones.
module traceback_row_packer
   import traceback_row_packer_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_dir,
   input  logic [PW-1:0]   in_x,
   input  logic [PW-1:0]   in_y,
   input  logic            in_last,
   output logic            mem_wr_valid,
   input  logic            mem_wr_ready,
   output logic [AW-1:0]   mem_wr_addr,
   output logic [N*DW-1:0] mem_wr_data,
   output logic [N-1:0]    mem_wr_mask,
   output logic            busy
);
   state_e state_q, state_d;
   logic acc_cl_q, acc_cl_d;
   logic acc_v, out_v, acc_v_d, out_v_d;
   logic accept, hit, close_now, spill, move, out_load;
   logic [TW-1:0]   in_tag, acc_tag, out_tag, ld_tag;
   logic [N*DW-1:0] acc_data, acc_wdata, out_data, ld_data;
   logic [N-1:0]    acc_mask, acc_wmask, out_mask, ld_mask;
   logic [N*DW-1:0] unused_out_wdata;
   logic [N-1:0]    unused_out_wmask;

   assign in_tag = {in_x, in_y[PW-1:LOG_N]};

   // acc_cl_q marks an ACC that must close but could not reach OUT yet (in_last on a tag change).
   always_comb begin
      acc_v     = state_q inside {ACCUM, PEND_ACCUM};
      out_v     = state_q inside {PEND, PEND_ACCUM};
      in_ready  = !out_v || mem_wr_ready;
      accept    = in_valid && in_ready;
      hit       = acc_v && !acc_cl_q && in_tag == acc_tag;
      close_now = accept && (hit || !acc_v) && (in_last || &acc_wmask);
      spill     = accept && acc_v && !hit;
      move      = !accept && acc_v && acc_cl_q && in_ready;
      out_load  = close_now || spill || move;
      ld_data   = close_now ? acc_wdata : acc_data;
      ld_mask   = close_now ? acc_wmask : acc_mask;
      ld_tag    = close_now ? in_tag : acc_tag;
      acc_v_d   = accept ? !close_now : acc_v && !move;
      out_v_d   = out_load || (out_v && !mem_wr_ready);
      acc_cl_d  = spill ? in_last : (move || close_now) ? 1'b0 : acc_cl_q;
      state_d   = out_v_d ? (acc_v_d ? PEND_ACCUM : PEND) : (acc_v_d ? ACCUM : EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         acc_cl_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_cl_q <= acc_cl_d;
      end
   end

   traceback_row_slot u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_i    (1'b0),
      .wr_i    (accept && !close_now),
      .fresh_i (!hit),
      .j_i     (in_y[LOG_N-1:0]),
      .dir_i   (in_dir),
      .data_i  ('0),
      .mask_i  ('0),
      .tag_i   (in_tag),
      .data_o  (acc_data),
      .mask_o  (acc_mask),
      .tag_o   (acc_tag),
      .wdata_o (acc_wdata),
      .wmask_o (acc_wmask)
   );

   traceback_row_slot u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_i    (out_load),
      .wr_i    (1'b0),
      .fresh_i (1'b0),
      .j_i     ('0),
      .dir_i   ('0),
      .data_i  (ld_data),
      .mask_i  (ld_mask),
      .tag_i   (ld_tag),
      .data_o  (out_data),
      .mask_o  (out_mask),
      .tag_o   (out_tag),
      .wdata_o (unused_out_wdata),
      .wmask_o (unused_out_wmask)
   );

   assign mem_wr_valid = out_v;
   assign mem_wr_addr  = row_addr(out_tag);
   assign mem_wr_data  = out_data;
   assign busy         = acc_v || out_v;
`ifdef TRACEBACK_WRITE_MASK_EN
   assign mem_wr_mask  = out_mask;
`else
   logic [N-1:0] unused_out_mask;
   assign unused_out_mask = out_mask;
   assign mem_wr_mask  = {N{out_v}};
`endif
endmodule

// File: tb/tb_traceback_row_packer.sv
// tb_traceback_row_packer: directed and randomized stimulus for traceback_row_packer,
// scored against a code-sequence model of row formation.
module tb_traceback_row_packer;
   import traceback_row_packer_pkg::*;

`ifdef TRACEBACK_WRITE_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0]   a;
      logic [N*DW-1:0] d;
      logic [N-1:0]    m;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   in_dir = '0;
   logic [PW-1:0]   in_x = '0;
   logic [PW-1:0]   in_y = '0;
   logic            in_last = 1'b0;
   logic            mem_wr_valid;
   logic            mem_wr_ready = 1'b1;
   logic [AW-1:0]   mem_wr_addr;
   logic [N*DW-1:0] mem_wr_data;
   logic [N-1:0]    mem_wr_mask;
   logic            busy;

   int n_tests = 0;
   int n_fail  = 0;
   int rdy_force = 1;
   bit saw_stall = 1'b0;
   wr_t exp_q[$];
   wr_t log_q[$];

   logic            m_v = 1'b0;
   logic [PW-1:0]   m_x, m_yw;
   logic [DW-1:0]   m_dir[N];
   bit              m_wr[N];

   traceback_row_packer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_dir       (in_dir),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_last      (in_last),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_mask  (mem_wr_mask),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_clear();
      m_v = 1'b0;
      for (int j = 0; j < N; j++) m_wr[j] = 1'b0;
   endfunction

   // Row word from the model: entry 0 shifted in first so it ends up most significant.
   function automatic void m_emit();
      wr_t w;
      w.a = AW'((int'(m_x) % (1 << ROW_WORDS_LOG)) * (1 << (PW-LOG_N)) + int'(m_yw));
      w.d = '0;
      w.m = '0;
      for (int j = 0; j < N; j++) begin
         w.d = (w.d << DW) | (N*DW)'(m_wr[j] ? int'(m_dir[j]) : 0);
         w.m = (w.m << 1) | N'(m_wr[j]);
      end
      if (!MASK_EN) w.m = '1;
      exp_q.push_back(w);
      m_clear();
   endfunction

   function automatic void m_push(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                  input logic [DW-1:0] d, input logic l);
      int j;
      int yw;
      bit full;
      j  = int'(y) % N;
      yw = int'(y) / N;
      if (m_v && (x != m_x || PW'(yw) != m_yw)) m_emit();
      if (!m_v) begin
         m_v  = 1'b1;
         m_x  = x;
         m_yw = PW'(yw);
      end
      m_dir[j] = d;
      m_wr[j]  = 1'b1;
      full = 1'b1;
      for (int k = 0; k < N; k++) full = full && m_wr[k];
      if (l || full) m_emit();
   endfunction

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [PW-1:0] x, input logic [PW-1:0] y, input logic [DW-1:0] d,
                       input logic l, output int waits);
      in_valid = 1'b1;
      in_x = x;
      in_y = y;
      in_dir = d;
      in_last = l;
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 200) begin
            check("in_ready_timeout", 0, 1);
            $fatal(1, "in_ready never returned");
         end
         @(posedge clk);
         #1;
      end
      m_push(x, y, d, l);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
      end
      check("idle_busy", busy, 0);
      check("idle_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      mem_wr_ready = rdy_force == 1 ? 1'b1 : rdy_force == 2 ? 1'b0 : ($urandom_range(0, 9) < 7);
   end

   initial begin
      bit  prev_stall = 1'b0;
      wr_t prev, e, w;
      forever begin
         @(negedge clk);
         if (!rst_n) prev_stall = 1'b0;
         else begin
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (prev_stall) begin
               check("hold_valid", mem_wr_valid, 1);
               check("hold_addr", mem_wr_addr, prev.a);
               check("hold_data", mem_wr_data, prev.d);
               check("hold_mask", mem_wr_mask, prev.m);
            end
            if (mem_wr_valid && mem_wr_ready) begin
               w.a = mem_wr_addr;
               w.d = mem_wr_data;
               w.m = mem_wr_mask;
               log_q.push_back(w);
               if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("sb_addr", w.a, e.a);
                  check("sb_data", w.d, e.d);
                  check("sb_mask", w.m, e.m);
               end
            end
            prev_stall = mem_wr_valid && !mem_wr_ready;
            prev.a = mem_wr_addr;
            prev.d = mem_wr_data;
            prev.m = mem_wr_mask;
         end
      end
   end

   initial begin
      int w, tw;
      int x, y;
      bit l;
      m_clear();
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_valid", mem_wr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_mask", mem_wr_mask, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Aligned fill: codes 0,1,2,3,... into x=3 y=0..7.
      rdy_force = 1;
      @(posedge clk);
      #1;
      log_q.delete();
      for (int i = 0; i < 8; i++) send(8'd3, PW'(i), DW'(i % 4), 1'b0, w);
      check("aligned_valid", mem_wr_valid, 1);
      check("aligned_addr", mem_wr_addr, 12'h060);
      check("aligned_data", mem_wr_data, 16'h1B1B);
      check("aligned_mask", mem_wr_mask, 8'hFF);
      wait_idle();
      check("aligned_count", log_q.size(), 1);

      // Unaligned segment y=5..10 on x=1, closed by in_last.
      log_q.delete();
      for (int i = 5; i <= 10; i++) send(8'd1, PW'(i), DW'(i % 4), i == 10, w);
      wait_idle();
      check("unal_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("unal0_addr", log_q[0].a, 12'h020);
         check("unal0_data", log_q[0].d, 16'h001B);
         check("unal0_mask", log_q[0].m, MASK_EN ? 8'b00000111 : 8'hFF);
         check("unal1_addr", log_q[1].a, 12'h021);
         check("unal1_data", log_q[1].d, 16'h1800);
         check("unal1_mask", log_q[1].m, MASK_EN ? 8'b11100000 : 8'hFF);
      end

      // Row change mid-word: no stall on the tag switch.
      log_q.delete();
      tw = 0;
      for (int i = 0; i < 3; i++) begin
         send(8'd2, PW'(i), DW'(3 - i), 1'b0, w);
         tw += w;
      end
      send(8'd3, 8'd3, 2'd0, 1'b1, w);
      tw += w;
      check("rowchg_waits", tw, 0);
      wait_idle();
      check("rowchg_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("rowchg0_addr", log_q[0].a, 12'h040);
         check("rowchg0_data", log_q[0].d, 16'hE400);
         check("rowchg0_mask", log_q[0].m, MASK_EN ? 8'b11100000 : 8'hFF);
         check("rowchg1_addr", log_q[1].a, 12'h060);
         check("rowchg1_mask", log_q[1].m, MASK_EN ? 8'b00010000 : 8'hFF);
      end

      // Backpressure during a 16-code stream.
      log_q.delete();
      saw_stall = 1'b0;
      fork
         for (int i = 0; i < 16; i++) send(8'd4, PW'(i + 16), DW'($urandom_range(0, 3)), i == 15, w);
         begin
            repeat (6) @(posedge clk);
            #1;
            rdy_force = 2;
            repeat (5) @(posedge clk);
            #1;
            rdy_force = 1;
         end
      join
      wait_idle();
      check("bp_stall_seen", saw_stall, 1);
      check("bp_count", log_q.size(), 2);

      // Reset with three entries held in ACC.
      log_q.delete();
      for (int i = 0; i < 3; i++) send(8'd5, PW'(i), 2'd1, 1'b0, w);
      rst_n = 1'b0;
      m_clear();
      #1;
      check("midrst_valid", mem_wr_valid, 0);
      check("midrst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("postrst_in_ready", in_ready, 1);
      check("postrst_valid", mem_wr_valid, 0);
      check("postrst_addr", mem_wr_addr, 0);
      check("postrst_data", mem_wr_data, 0);
      check("postrst_mask", mem_wr_mask, 0);
      check("postrst_busy", busy, 0);
      @(posedge clk);
      #1;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_write", log_q.size(), 0);

      // Randomized stream with random backpressure.
      rdy_force = 0;
      x = 0;
      y = 0;
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0) x = $urandom_range(0, 20);
         if (r < 2) y = $urandom_range(0, 255);
         else if (r != 2) y = (y + 1) % 256;
         l = ($urandom_range(0, 19) == 0) || i == 399;
         send(PW'(x), PW'(y), DW'($urandom_range(0, 3)), l, w);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rdy_force = 1;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
